dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_align.sv | 57 +++++
 rtl/dmem_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// ============================================================================
// dmem_pkg : access-size encodings and controller FSM state type
// Rev 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_INV  = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_WAIT = 2'b01;
  localparam state_t ST_RESP = 2'b10;

endpackage

`default_nettype wire

// File: rtl/dmem_align.sv
// ============================================================================
// dmem_align : byte-lane steering for stores and lane extraction for loads
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        fault_o
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shifted = rword_i >> {addr_i, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = addr_i[1] ? rword_i[31:16] : rword_i[15:0];

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = 32'h0;
    fault_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{~unsigned_i & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{~unsigned_i & w_half[15]}}, w_half};
        fault_o = addr_i[0];
      end
      SZ_WORD: begin
        be_o    = 4'b1111;
        rdata_o = rword_i;
        fault_o = |addr_i;
      end
      default: fault_o = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_ctrl.sv
// ============================================================================
// dmem_ctrl : single-port data memory with sized/extended access and fixed
//             response latency of WAIT_CYCLES+1 cycles
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Not reset; the initialiser only gives simulation a defined start.
  logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};

  logic          w_accept;
  logic          w_fault;
  logic          w_align_fault;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rword;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata_rep;
  logic [31:0]   w_ext;

  assign w_accept = req_valid && (state_q == ST_IDLE);
  assign w_idx    = req_addr[AW+1:2];
  assign w_rword  = mem_q[w_idx];
  // Power-of-two depth: any address bit above the index means out of range.
  assign w_fault  = w_align_fault | (|req_addr[31:AW+2]);

  dmem_align u_align (
    .size_i     (req_size),
    .addr_i     (req_addr[1:0]),
    .unsigned_i (req_unsigned),
    .wdata_i    (req_wdata),
    .rword_i    (w_rword),
    .be_o       (w_be),
    .wdata_o    (w_wdata_rep),
    .rdata_o    (w_ext),
    .fault_o    (w_align_fault)
  );

  always_ff @(posedge clk) begin
    if (w_accept && req_we && !w_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) mem_q[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          err_d   = w_fault;
          rdata_d = (w_fault || req_we) ? 32'h0 : w_ext;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
  assign rsp_err   = rsp_valid & err_q;

endmodule

`default_nettype wire
